i2c_bus_monitor: RTL and testbench
==================================

// Module: i2c_bus_monitor
// PURPOSE
//  Downstream consumer of the SCL/SDA line buffers: takes the stable, filtered line levels (sSignal) of both
//  tristate_buffer instances plus our own output enables, and produces bus events for the bit/byte controllers.
//  Detects START/repeated-START/STOP and SCL edges, tracks bus busy, samples data bits and bytes,
//  flags arbitration loss, and times out on excessive SCL stretching.
// PARAMETERS
//  TO_W     16  width of stretch-timeout compare value and counter
// PORTS
//  clk          in   1     system clock
//  rst          in   1     asynchronous, active-high reset
//  ena          in   1     core enable; low = monitor idle (see BEHAVIOUR)
//  scl_s        in   1     filtered SCL level (sSignal of SCL buffer), already synchronous to clk
//  sda_s        in   1     filtered SDA level (sSignal of SDA buffer)
//  scl_oen      in   1     our SCL output enable, 1 = released, 0 = driving low
//  sda_oen      in   1     our SDA output enable, 1 = released, 0 = driving low
//  master_act   in   1     we own the bus as master (enables arbitration checks)
//  stop_exp     in   1     our controller is issuing a STOP
//  to_cnt       in   TO_W  stretch timeout in clk cycles; 0 = timeout disabled
//  flag_clr     in   1     one-cycle pulse: clears al_flag and stretch_to
//  start_det    out  1     pulse: START seen while bus idle
//  rstart_det   out  1     pulse: START seen while bus busy (repeated START)
//  stop_det     out  1     pulse: STOP seen
//  busy         out  1     bus busy (START .. STOP)
//  scl_rise     out  1     pulse: SCL 0->1
//  scl_fall     out  1     pulse: SCL 1->0
//  bit_valid    out  1     pulse: data bit captured (with sda_bit)
//  sda_bit      out  1     last captured SDA bit
//  byte_valid   out  1     pulse: 8th bit of a frame captured
//  byte_out     out  8     last completed byte, MSB first
//  ack_valid    out  1     pulse: 9th (ACK) bit captured; ack_bit = sda_bit (0 = ACK)
//  al           out  1     pulse: arbitration lost
//  al_flag      out  1     sticky arbitration-lost flag
//  stretch      out  1     SCL released by us but held low on the line
//  stretch_to   out  1     sticky stretch timeout
// BEHAVIOUR
//  - Reset: all outputs 0; history regs scl_d/sda_d = 1 (idle bus); bit_cnt = 0; shift reg = 0; stretch counter = 0.
//  - History: scl_d<=scl_s, sda_d<=sda_s every cycle, regardless of ena (no spurious edges on enable).
//  - All outputs registered; latency 1: the edge that first samples a new level sets the pulse, high one cycle.
//  - scl_rise = scl_s&~scl_d; scl_fall = ~scl_s&scl_d.
//  - START: scl_s&scl_d&sda_d&~sda_s. Goes to start_det if busy=0, else rstart_det. Sets busy, bit_cnt<=0.
//  - STOP: scl_s&scl_d&~sda_d&sda_s. Pulses stop_det, clears busy, bit_cnt<=0. STOP has priority over busy set.
//  - Bit capture on scl_rise while busy: sda_bit<=sda_s, bit_valid; bit_cnt 0..8 wrap to 0 after 8.
//    bit_cnt 0..7: shift into byte reg MSB first; at bit_cnt=7 byte_out<=completed byte, byte_valid.
//    bit_cnt 8: ack_valid, no shift. START/STOP in the same cycle as scl_rise cannot occur (scl_d must be 1).
//  - Arbitration lost (only when master_act=1): (a) scl_rise & sda_oen & ~sda_s; (b) stop_det & ~stop_exp.
//    al pulses; al_flag set, held until flag_clr or rst. Set wins over a simultaneous flag_clr.
//  - stretch = busy & scl_oen & ~scl_s (registered). Counter increments while stretch, saturates at to_cnt,
//    clears when stretch drops. stretch_to set when counter reaches to_cnt and to_cnt!=0; sticky until flag_clr.
//  - ena=0: all pulses, busy, stretch, counter, bit_cnt forced 0; byte_out, sda_bit, sticky flags hold.
//    Re-enabling mid-transfer: busy stays 0 until the next START.
//  - rst asserted mid-transfer: immediate return to reset values; no pulse emitted.
// STRUCTURE
//  - Shared include i2c_defines.vh: I2C_FRAME_BITS=9, I2C_DATA_BITS=8, idle line level constant.
//  - One sub-module i2c_line_edge (per line: history reg, rise/fall/level outputs); instantiated for SCL and SDA.
//  - Remainder in this file: condition decode, bit/byte counter, arbitration, stretch timer.
// TESTING
//  - After rst, SDA 1->0 with SCL=1 -> start_det=1 one cycle later, busy=1; SDA 0->1 with SCL=1 -> stop_det, busy=0.
//  - START, clock 0xA5 + SDA=0 on 9th bit -> byte_valid with byte_out=8'hA5, then ack_valid with sda_bit=0.
//  - START, 3 bits, second START -> rstart_det=1, start_det=0, next byte starts at bit_cnt=0.
//  - master_act=1, sda_oen=1, sda_s=0 at scl_rise -> al=1 one cycle, al_flag=1 until flag_clr.
//  - to_cnt=15, scl_oen=1, SCL held low 20 cycles -> stretch_to=1 after 15 stretch cycles; to_cnt=0 -> never set.
//  - ena=0 during transfer, toggle lines -> no pulses, busy=0; ena=1 then START -> start_det normal.

Source files
------------

// File: rtl/i2c_bus_monitor_pkg.sv
// Shared constants, bus state type and bit-counter helper for the I2C bus monitor.
package i2c_bus_monitor_pkg;

  // Frame layout: 8 data bits followed by one ACK bit.
  localparam int unsigned I2C_FRAME_BITS = 9;
  localparam int unsigned I2C_DATA_BITS  = 8;

  // Level of a released (idle) I2C line.
  localparam logic I2C_IDLE_LEVEL = 1'b1;

  // Width of the in-frame bit counter (must hold 0..I2C_FRAME_BITS-1).
  localparam int unsigned BIT_CNT_W = 4;

  // Bus ownership state as seen on the wire.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_t;

  // Advance the frame bit counter, wrapping after the ACK bit.
  function automatic logic [BIT_CNT_W-1:0] bit_cnt_next(input logic [BIT_CNT_W-1:0] cnt);
    if (cnt == BIT_CNT_W'(I2C_FRAME_BITS - 1)) begin
      return '0;
    end
    return cnt + BIT_CNT_W'(1);
  endfunction

  // True for bit positions that belong to the data byte (not the ACK slot).
  function automatic logic is_data_bit(input logic [BIT_CNT_W-1:0] cnt);
    return (cnt < BIT_CNT_W'(I2C_DATA_BITS));
  endfunction

  // True for the last data bit of a frame.
  function automatic logic is_last_data_bit(input logic [BIT_CNT_W-1:0] cnt);
    return (cnt == BIT_CNT_W'(I2C_DATA_BITS - 1));
  endfunction

endpackage

// File: rtl/i2c_bus_monitor_line_edge.sv
// Per-line history register with combinational rise/fall decode.
// History resets to the idle line level so no edge appears out of reset.
module i2c_line_edge
  import i2c_bus_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic lvl_d,
  output logic rise,
  output logic fall
);

  // Track the previous line level every cycle, independent of core enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_d <= I2C_IDLE_LEVEL;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: decodes START/STOP and SCL edges from filtered line levels,
// tracks bus busy, captures data/ACK bits, detects arbitration loss and
// times out on excessive SCL stretching. All outputs are registered.
module i2c_bus_monitor
  import i2c_bus_monitor_pkg::*;
#(
  parameter int unsigned TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            scl_s,
  input  logic            sda_s,
  input  logic            scl_oen,
  input  logic            sda_oen,
  input  logic            master_act,
  input  logic            stop_exp,
  input  logic [TO_W-1:0] to_cnt,
  input  logic            flag_clr,
  output logic            start_det,
  output logic            rstart_det,
  output logic            stop_det,
  output logic            busy,
  output logic            scl_rise,
  output logic            scl_fall,
  output logic            bit_valid,
  output logic            sda_bit,
  output logic            byte_valid,
  output logic [7:0]      byte_out,
  output logic            ack_valid,
  output logic            al,
  output logic            al_flag,
  output logic            stretch,
  output logic            stretch_to
);

  logic scl_d, scl_r, scl_f;
  logic sda_d, sda_r, sda_f;

  logic start_c, stop_c, bit_cap, al_c;

  bus_state_t state, state_nxt;

  logic [BIT_CNT_W-1:0]     bit_cnt;
  logic [I2C_DATA_BITS-1:0] shreg;
  logic [I2C_DATA_BITS-1:0] shreg_nxt;
  logic [TO_W-1:0]          str_cnt;

  i2c_line_edge u_scl_edge (
    .clk   (clk),
    .rst   (rst),
    .lvl   (scl_s),
    .lvl_d (scl_d),
    .rise  (scl_r),
    .fall  (scl_f)
  );

  i2c_line_edge u_sda_edge (
    .clk   (clk),
    .rst   (rst),
    .lvl   (sda_s),
    .lvl_d (sda_d),
    .rise  (sda_r),
    .fall  (sda_f)
  );

  // SDA transitions with SCL stable high are bus conditions, not data.
  assign start_c   = scl_s & scl_d & sda_f;
  assign stop_c    = scl_s & scl_d & sda_r;
  assign bit_cap   = ena & busy & scl_r;
  assign shreg_nxt = {shreg[I2C_DATA_BITS-2:0], sda_s};

  // Arbitration loss: released SDA read back low, or a STOP we did not issue.
  assign al_c = ena & master_act & ((scl_r & sda_oen & ~sda_s) | (stop_c & ~stop_exp));

  // Busy is the bus state register itself.
  assign busy = (state == ST_BUSY);

  // Bus state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus state transitions; STOP wins over START, disable forces idle.
  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = ST_IDLE;
    end else if (stop_c) begin
      state_nxt = ST_IDLE;
    end else if (start_c) begin
      state_nxt = ST_BUSY;
    end
  end

  // Condition and SCL edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
    end else begin
      start_det  <= ena & start_c & ~busy;
      rstart_det <= ena & start_c & busy;
      stop_det   <= ena & stop_c;
      scl_rise   <= ena & scl_r;
      scl_fall   <= ena & scl_f;
    end
  end

  // Bit/byte capture and frame bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      sda_bit    <= 1'b0;
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      ack_valid  <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      ack_valid  <= 1'b0;
      if (!ena) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (start_c || stop_c) begin
        bit_cnt <= '0;
      end else if (bit_cap) begin
        sda_bit   <= sda_s;
        bit_valid <= 1'b1;
        bit_cnt   <= bit_cnt_next(bit_cnt);
        if (is_data_bit(bit_cnt)) begin
          shreg <= shreg_nxt;
          if (is_last_data_bit(bit_cnt)) begin
            byte_out   <= shreg_nxt;
            byte_valid <= 1'b1;
          end
        end else begin
          ack_valid <= 1'b1;
        end
      end
    end
  end

  // Arbitration-lost pulse and sticky flag; a new loss beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al      <= 1'b0;
      al_flag <= 1'b0;
    end else begin
      al <= al_c;
      if (al_c) begin
        al_flag <= 1'b1;
      end else if (flag_clr) begin
        al_flag <= 1'b0;
      end
    end
  end

  // SCL stretch detection, saturating stretch counter and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch    <= 1'b0;
      str_cnt    <= '0;
      stretch_to <= 1'b0;
    end else begin
      stretch <= ena & busy & scl_oen & ~scl_s;
      if (!ena || !stretch) begin
        str_cnt <= '0;
      end else if (str_cnt != to_cnt) begin
        str_cnt <= str_cnt + TO_W'(1);
      end
      if (ena && stretch && (to_cnt != '0) && (str_cnt == to_cnt)) begin
        stretch_to <= 1'b1;
      end else if (flag_clr) begin
        stretch_to <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed self-checking bench for i2c_bus_monitor.
module tb_i2c_bus_monitor;

  logic        clk = 1'b0;
  logic        rst, ena, scl_s, sda_s, scl_oen, sda_oen, master_act, stop_exp, flag_clr;
  logic [15:0] to_cnt;
  logic        start_det, rstart_det, stop_det, busy, scl_rise, scl_fall;
  logic        bit_valid, sda_bit, byte_valid, ack_valid, al, al_flag, stretch, stretch_to;
  logic [7:0]  byte_out;

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [7:0]  data;

  i2c_bus_monitor #(.TO_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .scl_s      (scl_s),
    .sda_s      (sda_s),
    .scl_oen    (scl_oen),
    .sda_oen    (sda_oen),
    .master_act (master_act),
    .stop_exp   (stop_exp),
    .to_cnt     (to_cnt),
    .flag_clr   (flag_clr),
    .start_det  (start_det),
    .rstart_det (rstart_det),
    .stop_det   (stop_det),
    .busy       (busy),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .bit_valid  (bit_valid),
    .sda_bit    (sda_bit),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .ack_valid  (ack_valid),
    .al         (al),
    .al_flag    (al_flag),
    .stretch    (stretch),
    .stretch_to (stretch_to)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // SDA falls while SCL is high (caller leaves SCL=1, SDA=1).
  task automatic do_start();
    sda_s = 1'b0;
    tick();
  endtask

  // SCL low, SDA low, SCL high, SDA rises -> STOP on the last tick.
  task automatic do_stop();
    scl_s = 1'b0; tick();
    sda_s = 1'b0; tick();
    scl_s = 1'b1; tick();
    sda_s = 1'b1; tick();
  endtask

  // One data bit: SCL low, set SDA, SCL high; returns right after the rise is sampled.
  task automatic clk_bit(input logic b);
    scl_s = 1'b0; tick();
    sda_s = b;    tick();
    scl_s = 1'b1; tick();
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; scl_s = 1'b1; sda_s = 1'b1;
    scl_oen = 1'b1; sda_oen = 1'b1; master_act = 1'b0; stop_exp = 1'b0;
    to_cnt = 16'd0; flag_clr = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", start_det, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_alflag", al_flag, 0);
    chk("rst_sto", stretch_to, 0);
    rst = 1'b0;
    tick();
    chk("idle_rise", scl_rise, 0);

    // Basic START / STOP
    do_start();
    chk("t1_start", start_det, 1);
    chk("t1_rstart", rstart_det, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_start_pulse", start_det, 0);
    do_stop();
    chk("t1_stop", stop_det, 1);
    chk("t1_busy_clr", busy, 0);
    tick();
    chk("t1_stop_pulse", stop_det, 0);

    // Byte 0xA5 followed by ACK=0
    do_start();
    scl_s = 1'b0; tick();
    chk("t2_fall", scl_fall, 1);
    data = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(data[i]);
      chk("t2_bitv", bit_valid, 1);
      chk("t2_sdabit", sda_bit, data[i]);
      if (i == 7) chk("t2_rise", scl_rise, 1);
      if (i == 1) chk("t2_byte_early", byte_valid, 0);
    end
    chk("t2_bytev", byte_valid, 1);
    chk("t2_byte", byte_out, 8'hA5);
    chk("t2_noack", ack_valid, 0);
    clk_bit(1'b0);
    chk("t2_ackv", ack_valid, 1);
    chk("t2_ackbit", sda_bit, 0);
    chk("t2_ack_nobyte", byte_valid, 0);
    chk("t2_al_slave", al, 0);
    do_stop();
    chk("t2_stop", stop_det, 1);

    // Repeated START restarts the bit counter
    do_start();
    clk_bit(1'b1); clk_bit(1'b0); clk_bit(1'b1);
    scl_s = 1'b0; tick();
    sda_s = 1'b1; tick();
    scl_s = 1'b1; tick();
    sda_s = 1'b0; tick();
    chk("t3_rstart", rstart_det, 1);
    chk("t3_nostart", start_det, 0);
    chk("t3_busy", busy, 1);
    data = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(data[i]);
      if (i != 0) chk("t3_byte_early", byte_valid, 0);
    end
    chk("t3_bytev", byte_valid, 1);
    chk("t3_byte", byte_out, 8'h3C);
    clk_bit(1'b1);
    chk("t3_ackv", ack_valid, 1);
    chk("t3_nack", sda_bit, 1);
    do_stop();

    // Arbitration loss
    master_act = 1'b1;
    do_start();
    clk_bit(1'b1);
    chk("t4_no_al", al, 0);
    clk_bit(1'b0);
    chk("t4_al", al, 1);
    chk("t4_alflag", al_flag, 1);
    tick();
    chk("t4_al_pulse", al, 0);
    chk("t4_alflag_hold", al_flag, 1);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    chk("t4_alflag_clr", al_flag, 0);
    do_stop();
    chk("t4_al_stop", al, 1);
    chk("t4_stop", stop_det, 1);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    chk("t4_clr2", al_flag, 0);
    stop_exp = 1'b1;
    do_start();
    sda_oen = 1'b0;
    do_stop();
    chk("t4_stop_exp", al, 0);
    chk("t4_stop_exp_flag", al_flag, 0);
    sda_oen = 1'b1; stop_exp = 1'b0; master_act = 1'b0;
    tick();

    // SCL stretch timeout
    to_cnt = 16'd15;
    do_start();
    scl_oen = 1'b0; scl_s = 1'b0;
    tick(); tick();
    chk("t5_own_low", stretch, 0);
    scl_oen = 1'b1;
    repeat (10) tick();
    chk("t5_stretch", stretch, 1);
    chk("t5_sto_early", stretch_to, 0);
    repeat (6) tick();
    chk("t5_sto_16", stretch_to, 0);
    tick();
    chk("t5_sto_17", stretch_to, 1);
    repeat (3) tick();
    scl_s = 1'b1; tick(); tick();
    chk("t5_stretch_off", stretch, 0);
    chk("t5_sto_sticky", stretch_to, 1);
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    chk("t5_sto_clr", stretch_to, 0);
    to_cnt = 16'd0;
    scl_s = 1'b0;
    repeat (20) tick();
    chk("t5_stretch0", stretch, 1);
    chk("t5_sto_dis", stretch_to, 0);
    scl_s = 1'b1; tick();
    do_stop();

    // Enable low during a transfer
    do_start();
    clk_bit(1'b1); clk_bit(1'b0);
    ena = 1'b0; tick();
    chk("t6_busy_off", busy, 0);
    scl_s = 1'b0; tick();
    chk("t6_nofall", scl_fall, 0);
    scl_s = 1'b1; tick();
    chk("t6_norise", scl_rise, 0);
    chk("t6_nobit", bit_valid, 0);
    sda_s = 1'b1; tick();
    chk("t6_nostop", stop_det, 0);
    sda_s = 1'b0; tick();
    chk("t6_nostart", start_det, 0);
    chk("t6_sdabit_hold", sda_bit, 0);
    sda_s = 1'b1; tick();
    ena = 1'b1; tick();
    chk("t6_busy_reen", busy, 0);
    do_start();
    chk("t6_start", start_det, 1);
    chk("t6_busy", busy, 1);

    // Asynchronous reset mid-transfer
    clk_bit(1'b1);
    chk("t7_pre_bit", sda_bit, 1);
    rst = 1'b1; #1;
    chk("t7_busy", busy, 0);
    chk("t7_sdabit", sda_bit, 0);
    chk("t7_byte", byte_out, 0);
    scl_s = 1'b1; sda_s = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t7_nopulse", start_det | stop_det | bit_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
